mem_2r2w_t1_resp: RTL and testbench

MEM_2R2W_T1_RESP -- requirements
Module: mem_2r2w_t1_resp

---
 rtl/mem_t1_pkg.sv | 19 +
 rtl/t1_rd_pipe.sv | 47 ++++
 rtl/mem_2r2w_t1_resp.sv | 148 ++++++++++++++
 tb/tb_mem_2r2w_t1_resp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_t1_pkg.sv
// Shared constants for the two-write / two-read memory with pipelined reads.
// Holds the default parameter values and the legal read-latency bounds used
// by the top-level elaboration check.
package mem_t1_pkg;

  localparam int WIDTH_DEF    = 15;
  localparam int NUMADDR_DEF  = 256;
  localparam int BITADDR_DEF  = 8;
  localparam int T1_DELAY_DEF = 1;

  localparam int T1_DELAY_MIN = 1;
  localparam int T1_DELAY_MAX = 4;

  // True when a latency value is within the supported pipeline depths.
  function automatic bit delay_legal(input int d);
    return (d >= T1_DELAY_MIN) && (d <= T1_DELAY_MAX);
  endfunction

endpackage

// File: rtl/t1_rd_pipe.sv
// Fixed-depth read-data delay line.
// Accepts one (valid, data) pair per cycle, never stalls, and presents it
// DEPTH cycles later. A stage only loads data when the incoming valid is set,
// so the final stage holds the last delivered word while out_vld is low.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (clears all stages)
//   in_vld, in_data   entry into stage 0
//   out_vld, out_data last stage
module t1_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/mem_2r2w_t1_resp.sv
// Two-write-port / two-read-port memory with fixed read latency.
// Write ports A and B apply per-bit masked writes; when both hit the same
// word in one cycle, A is merged first and B on top of it. Read ports C and D
// sample the array before this cycle's writes land (read-old) and deliver the
// word T1_DELAY cycles later through a t1_rd_pipe per port.
//
// Handshake: strobes have no ready; every cycle a port may accept a new
// request. Each read strobe produces exactly one t1_vldX pulse T1_DELAY
// cycles later, in issue order; t1_doutX is meaningful while t1_vldX=1 and
// holds its last delivered value otherwise.
//
// Out-of-range addresses (>= NUMADDR): writes are dropped, reads return zero
// with valid, and either sets the sticky t1_err flag until reset.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   t1_writeA/B, t1_addrA/B        write strobe and address
//   t1_dinA/B, t1_bwA/B            write data and per-bit enable
//   t1_readC/D, t1_addrC/D         read strobe and address
//   t1_vldC/D, t1_doutC/D          read response
//   t1_err                         sticky out-of-range access flag
module mem_2r2w_t1_resp
  import mem_t1_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NUMADDR  = NUMADDR_DEF,
  parameter int BITADDR  = BITADDR_DEF,
  parameter int T1_DELAY = T1_DELAY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               t1_writeA,
  input  logic [BITADDR-1:0] t1_addrA,
  input  logic [WIDTH-1:0]   t1_dinA,
  input  logic [WIDTH-1:0]   t1_bwA,
  input  logic               t1_writeB,
  input  logic [BITADDR-1:0] t1_addrB,
  input  logic [WIDTH-1:0]   t1_dinB,
  input  logic [WIDTH-1:0]   t1_bwB,
  input  logic               t1_readC,
  input  logic [BITADDR-1:0] t1_addrC,
  input  logic               t1_readD,
  input  logic [BITADDR-1:0] t1_addrD,
  output logic               t1_vldC,
  output logic [WIDTH-1:0]   t1_doutC,
  output logic               t1_vldD,
  output logic [WIDTH-1:0]   t1_doutD,
  output logic               t1_err
);

  if (!delay_legal(T1_DELAY) || ((2 ** BITADDR) < NUMADDR)) begin : g_param_check
    $error("mem_2r2w_t1_resp: T1_DELAY must be 1..4 and 2**BITADDR must cover NUMADDR");
  end

  // One extra bit so NUMADDR == 2**BITADDR is representable.
  localparam logic [BITADDR:0] ADDR_LIMIT = (BITADDR+1)'(NUMADDR);

  logic [WIDTH-1:0] mem [NUMADDR];

  logic a_ok, b_ok, c_ok, d_ok;
  logic a_bad, b_bad, c_bad, d_bad;
  logic [WIDTH-1:0] a_word, b_base, b_word;
  logic [WIDTH-1:0] c_rdata, d_rdata;
  logic err_q;

  assign a_ok = ({1'b0, t1_addrA} < ADDR_LIMIT);
  assign b_ok = ({1'b0, t1_addrB} < ADDR_LIMIT);
  assign c_ok = ({1'b0, t1_addrC} < ADDR_LIMIT);
  assign d_ok = ({1'b0, t1_addrD} < ADDR_LIMIT);

  assign a_bad = t1_writeA && !a_ok;
  assign b_bad = t1_writeB && !b_ok;
  assign c_bad = t1_readC  && !c_ok;
  assign d_bad = t1_readD  && !d_ok;

  // Merged words. When A and B target the same word, B merges onto A's
  // result rather than the stored word, so both writes take effect.
  always_comb begin
    a_word = '0;
    b_base = '0;
    b_word = '0;
    if (a_ok) begin
      a_word = (mem[t1_addrA] & ~t1_bwA) | (t1_dinA & t1_bwA);
    end
    if (b_ok) begin
      b_base = (t1_writeA && a_ok && (t1_addrA == t1_addrB)) ? a_word : mem[t1_addrB];
      b_word = (b_base & ~t1_bwB) | (t1_dinB & t1_bwB);
    end
  end

  // Array contents are intentionally not reset. B is assigned last so it
  // carries the combined word on a same-address collision.
  always_ff @(posedge clk) begin
    if (t1_writeA && a_ok) begin
      mem[t1_addrA] <= a_word;
    end
    if (t1_writeB && b_ok) begin
      mem[t1_addrB] <= b_word;
    end
  end

  // Read-old: the array is sampled combinationally before this edge's writes.
  always_comb begin
    c_rdata = '0;
    d_rdata = '0;
    if (c_ok) begin
      c_rdata = mem[t1_addrC];
    end
    if (d_ok) begin
      d_rdata = mem[t1_addrD];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (a_bad || b_bad || c_bad || d_bad) begin
      err_q <= 1'b1;
    end
  end

  assign t1_err = err_q;

  t1_rd_pipe #(
    .DEPTH (T1_DELAY),
    .WIDTH (WIDTH)
  ) u_pipe_c (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (t1_readC),
    .in_data  (c_rdata),
    .out_vld  (t1_vldC),
    .out_data (t1_doutC)
  );

  t1_rd_pipe #(
    .DEPTH (T1_DELAY),
    .WIDTH (WIDTH)
  ) u_pipe_d (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (t1_readD),
    .in_data  (d_rdata),
    .out_vld  (t1_vldD),
    .out_data (t1_doutD)
  );

endmodule

// File: tb/tb_mem_2r2w_t1_resp.sv
// Directed table-driven bench for mem_2r2w_t1_resp with WIDTH=15,
// NUMADDR=200, BITADDR=8, T1_DELAY=3.
module tb_mem_2r2w_t1_resp;

  localparam int W   = 15;
  localparam int AW  = 8;
  localparam int NA  = 200;
  localparam int DLY = 3;
  localparam int NV  = 17;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          t1_writeA, t1_writeB, t1_readC, t1_readD;
  logic [AW-1:0] t1_addrA, t1_addrB, t1_addrC, t1_addrD;
  logic [W-1:0]  t1_dinA, t1_dinB, t1_bwA, t1_bwB;
  logic          t1_vldC, t1_vldD, t1_err;
  logic [W-1:0]  t1_doutC, t1_doutD;

  mem_2r2w_t1_resp #(
    .WIDTH    (W),
    .NUMADDR  (NA),
    .BITADDR  (AW),
    .T1_DELAY (DLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .t1_writeA (t1_writeA),
    .t1_addrA  (t1_addrA),
    .t1_dinA   (t1_dinA),
    .t1_bwA    (t1_bwA),
    .t1_writeB (t1_writeB),
    .t1_addrB  (t1_addrB),
    .t1_dinB   (t1_dinB),
    .t1_bwB    (t1_bwB),
    .t1_readC  (t1_readC),
    .t1_addrC  (t1_addrC),
    .t1_readD  (t1_readD),
    .t1_addrD  (t1_addrD),
    .t1_vldC   (t1_vldC),
    .t1_doutC  (t1_doutC),
    .t1_vldD   (t1_vldD),
    .t1_doutD  (t1_doutD),
    .t1_err    (t1_err)
  );

  typedef struct {
    logic          wa;
    logic [AW-1:0] aa;
    logic [W-1:0]  da;
    logic [W-1:0]  ba;
    logic          wb;
    logic [AW-1:0] ab;
    logic [W-1:0]  db;
    logic [W-1:0]  bb;
    logic          rc;
    logic [AW-1:0] ac;
    logic [W-1:0]  ec;
    logic          rd;
    logic [AW-1:0] ad;
    logic [W-1:0]  ed;
  } vec_t;

  vec_t vecs [NV];
  vec_t idle_v;

  // Scoreboard
  logic [W-1:0] exp_c_q[$];
  logic [W-1:0] exp_d_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver
  task automatic drive_vec(input vec_t v);
    t1_writeA = v.wa; t1_addrA = v.aa; t1_dinA = v.da; t1_bwA = v.ba;
    t1_writeB = v.wb; t1_addrB = v.ab; t1_dinB = v.db; t1_bwB = v.bb;
    t1_readC  = v.rc; t1_addrC = v.ac;
    t1_readD  = v.rd; t1_addrD = v.ad;
    if (v.rc) exp_c_q.push_back(v.ec);
    if (v.rd) exp_d_q.push_back(v.ed);
  endtask

  function automatic bit vec_bad(input vec_t v);
    return (v.wa && v.aa >= AW'(NA)) || (v.wb && v.ab >= AW'(NA)) ||
           (v.rc && v.ac >= AW'(NA)) || (v.rd && v.ad >= AW'(NA));
  endfunction

  logic [W-1:0] held_c, held_d;
  logic         exp_err;

  initial begin
    idle_v = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0};
    //          wa aa   da       ba        wb ab   db       bb        rc ac   ec       rd ad   ed
    vecs[0]  = '{1, 5,   15'h1234, 15'h7FFF, 1, 9,   15'h0AAA, 15'h7FFF, 0, 0,   15'h0,   0, 0,   15'h0};
    vecs[1]  = '{1, 7,   15'h0000, 15'h7FFF, 0, 0,   15'h0,    15'h0,    1, 5,   15'h1234, 0, 0,  15'h0};
    vecs[2]  = '{1, 7,   15'h7FFF, 15'h00FF, 1, 7,   15'h0000, 15'h000F, 0, 0,   15'h0,   1, 9,   15'h0AAA};
    vecs[3]  = '{1, 9,   15'h0555, 15'h7FFF, 0, 0,   15'h0,    15'h0,    1, 7,   15'h00F0, 1, 9,  15'h0AAA};
    vecs[4]  = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 9,   15'h0555, 1, 9,  15'h0555};
    vecs[5]  = '{1, 0,   15'h0100, 15'h7FFF, 1, 1,   15'h0111, 15'h7FFF, 0, 0,   15'h0,   0, 0,   15'h0};
    vecs[6]  = '{1, 2,   15'h0222, 15'h7FFF, 1, 3,   15'h0333, 15'h7FFF, 0, 0,   15'h0,   0, 0,   15'h0};
    vecs[7]  = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 0,   15'h0100, 0, 0,  15'h0};
    vecs[8]  = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 1,   15'h0111, 0, 0,  15'h0};
    vecs[9]  = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 2,   15'h0222, 0, 0,  15'h0};
    vecs[10] = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 3,   15'h0333, 0, 0,  15'h0};
    vecs[11] = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    0, 0,   15'h0,   0, 0,   15'h0};
    vecs[12] = '{1, 5,   15'h7FFF, 15'h7000, 0, 0,   15'h0,    15'h0,    0, 0,   15'h0,   0, 0,   15'h0};
    vecs[13] = '{0, 0,   15'h0,    15'h0,    1, 5,   15'h0000, 15'h0004, 0, 0,   15'h0,   1, 5,   15'h7234};
    vecs[14] = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 5,   15'h7230, 0, 0,  15'h0};
    vecs[15] = '{1, 199, 15'h0199, 15'h7FFF, 0, 0,   15'h0,    15'h0,    0, 0,   15'h0,   0, 0,   15'h0};
    vecs[16] = '{0, 0,   15'h0,    15'h0,    0, 0,   15'h0,    15'h0,    1, 250, 15'h0000, 1, 199, 15'h0199};

    drive_vec(idle_v);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_vldC",  t1_vldC,  0);
    check("reset_vldD",  t1_vldD,  0);
    check("reset_doutC", t1_doutC, 0);
    check("reset_doutD", t1_doutD, 0);
    check("reset_err",   t1_err,   0);
    @(negedge clk);
    rst = 1'b1;

    // Table: vector k is driven in cycle k; its read answers after edge k+DLY-1.
    held_c  = '0;
    held_d  = '0;
    exp_err = 1'b0;
    for (int k = 0; k < NV + DLY - 1; k++) begin
      if (k < NV) drive_vec(vecs[k]);
      else        drive_vec(idle_v);
      @(posedge clk);
      #1;
      if (k < NV && vec_bad(vecs[k])) exp_err = 1'b1;
      begin
        int  j;
        logic ev_c, ev_d;
        j = k - (DLY - 1);
        ev_c = (j >= 0) ? vecs[j].rc : 1'b0;
        ev_d = (j >= 0) ? vecs[j].rd : 1'b0;
        if (ev_c && exp_c_q.size() > 0) held_c = exp_c_q.pop_front();
        if (ev_d && exp_d_q.size() > 0) held_d = exp_d_q.pop_front();
        check($sformatf("tbl%0d_vldC", j), t1_vldC, ev_c);
        check($sformatf("tbl%0d_vldD", j), t1_vldD, ev_d);
        check($sformatf("tbl%0d_doutC", j), t1_doutC, held_c);
        check($sformatf("tbl%0d_doutD", j), t1_doutD, held_d);
        check($sformatf("tbl%0d_err", k), t1_err, exp_err);
      end
    end
    check("scoreboard_c_empty", exp_c_q.size(), 0);
    check("scoreboard_d_empty", exp_d_q.size(), 0);

    // Sticky error across idle cycles; outputs hold last delivered data.
    drive_vec(idle_v);
    repeat (10) @(posedge clk);
    #1;
    check("err_sticky",  t1_err,   1);
    check("idle_vldC",   t1_vldC,  0);
    check("hold_doutC",  t1_doutC, 15'h0000);
    check("hold_doutD",  t1_doutD, 15'h0199);

    // Reset while a read is in flight.
    t1_readC = 1'b1;
    t1_addrC = 8'd5;
    @(posedge clk);
    #1;
    t1_readC = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_vldC",  t1_vldC,  0);
    check("midrst_doutC", t1_doutC, 0);
    check("midrst_doutD", t1_doutD, 0);
    check("midrst_err",   t1_err,   0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Strobe in the first cycle after release; memory survives reset.
    t1_readC = 1'b1;
    t1_addrC = 8'd5;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      t1_readC = 1'b0;
      check($sformatf("postrst%0d_vldC", i), t1_vldC, (i == DLY) ? 1 : 0);
      check($sformatf("postrst%0d_doutC", i), t1_doutC, (i >= DLY) ? 15'h7230 : 15'h0);
    end

    // Out-of-range write sets the error flag.
    check("pre_oor_err", t1_err, 0);
    t1_writeA = 1'b1;
    t1_addrA  = 8'd220;
    t1_dinA   = 15'h7FFF;
    t1_bwA    = 15'h7FFF;
    @(posedge clk);
    #1;
    t1_writeA = 1'b0;
    check("oor_write_err", t1_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
